// File: rtl/iob_native_fifo_slave_pkg.sv
// Shared definitions for the native-bus FIFO slave.
//   - window select: the address MSB picks the data window or the CSR window
//   - CSR word offsets (addr[3:2]) and CONTROL flush bit positions
//   - width of each level field in the STATUS word
package iob_native_fifo_slave_pkg;

  typedef enum logic {
    WIN_DATA = 1'b0,
    WIN_CSR  = 1'b1
  } win_e;

  typedef enum logic [1:0] {
    CSR_STATUS  = 2'd0,
    CSR_CONTROL = 2'd1
  } csr_idx_e;

  localparam int FLUSH_RX_BIT = 0;
  localparam int FLUSH_TX_BIT = 1;

  localparam int LVL_FIELD_W = 16;

endpackage

// File: rtl/iob_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   flush         empties the FIFO; a push/pop in the same cycle is discarded
//   push, push_data  write side
//   pop           read side; head always shows the oldest stored word
//   head          oldest word (valid when !empty)
//   full, empty   status flags
//   level         number of stored words, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module iob_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [LVL_W-1:0]  level_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign head  = mem[rptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries data only; its contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/iob_native_fifo_slave.sv
// Native-bus slave bridging a CPU/DMA master to a TX and an RX word stream.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   valid, addr, wdata, wstrb native request (wstrb != 0 -> write)
//   rdata, ready              native response, ready is combinational
//   tx_data, tx_valid, tx_ready  TX stream out (first-word fall-through)
//   rx_data, rx_valid, rx_ready  RX stream in
// Address map: addr MSB = 0 -> data window (any offset; write pushes TX,
// read pops RX, wait states while TX full / RX empty). addr MSB = 1 -> CSR
// window indexed by addr[3:2]: 0 STATUS {rx_level, tx_level}, 1 CONTROL
// (bit0 flush RX, bit1 flush TX). CSR accesses complete immediately.
module iob_native_fifo_slave
  import iob_native_fifo_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  win_e              win;
  logic [1:0]        csr_idx;
  logic              is_write;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_flush;
  logic              tx_full;
  logic              tx_empty;
  logic [LVL_W-1:0]  tx_level;

  logic              rx_push;
  logic              rx_pop;
  logic              rx_flush;
  logic              rx_full;
  logic              rx_empty;
  logic [LVL_W-1:0]  rx_level;
  logic [DATA_W-1:0] rx_head;

  logic              unused_addr;

  assign win      = win_e'(addr[ADDR_W-1]);
  assign csr_idx  = addr[3:2];
  assign is_write = |wstrb;

  // Only the window bit and the CSR index take part in decoding.
  assign unused_addr = ^{addr[ADDR_W-2:4], addr[1:0]};

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  // Request decode. Nothing completes while rst is high, so a request that
  // was in flight across a reset has to be reissued.
  always_comb begin
    ready    = 1'b0;
    rdata    = '0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    if (valid && !rst) begin
      if (win == WIN_CSR) begin
        ready = 1'b1;
        if (is_write) begin
          if (csr_idx == CSR_CONTROL) begin
            rx_flush = wdata[FLUSH_RX_BIT];
            tx_flush = wdata[FLUSH_TX_BIT];
          end
        end else if (csr_idx == CSR_STATUS) begin
          rdata = DATA_W'({LVL_FIELD_W'(rx_level), LVL_FIELD_W'(tx_level)});
        end
      end else if (is_write) begin
        if (!tx_full) begin
          ready   = 1'b1;
          tx_push = 1'b1;
        end
      end else begin
        if (!rx_empty) begin
          ready  = 1'b1;
          rdata  = rx_head;
          rx_pop = 1'b1;
        end
      end
    end
  end

  iob_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (tx_flush),
    .push      (tx_push),
    .push_data (wdata),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  iob_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (rx_flush),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

endmodule
